// File: rtl/paddle_controller.sv
// Paddle position controller: an immediate step on press, then auto-repeat after a
// long initial delay and at a faster rate. Position is clamped to 0..MAX_POS.
module paddle_controller #(
  parameter int POS_WIDTH    = 5,
  parameter int MAX_POS      = 27,
  parameter int RESET_POS    = 14,
  parameter int DELAY_CYCLES = 2500000,
  parameter int RATE_CYCLES  = 500000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 up,
  input  logic                 down,
  input  logic                 enable,
  input  logic                 recenter,
  output logic [POS_WIDTH-1:0] pos,
  output logic                 moved,
  output logic                 at_top,
  output logic                 at_bottom
);

  localparam int TIMER_MAX = (DELAY_CYCLES > RATE_CYCLES) ? DELAY_CYCLES : RATE_CYCLES;
  localparam int TW        = $clog2(TIMER_MAX);

  localparam logic [POS_WIDTH-1:0] MAX_P   = POS_WIDTH'(MAX_POS);
  localparam logic [POS_WIDTH-1:0] RESET_P = POS_WIDTH'(RESET_POS);
  localparam logic [TW-1:0]        DELAY_T = TW'(DELAY_CYCLES - 1);
  localparam logic [TW-1:0]        RATE_T  = TW'(RATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  state_t                 state, state_n;
  logic                   dir, dir_n;
  logic [TW-1:0]          timer, timer_n;
  logic [POS_WIDTH-1:0]   pos_n;
  logic                   moved_n;
  logic                   req_up, req_dn, has_req, req_dir;
  logic                   do_step;

  // dir / req_dir encoding: 0 = toward 0 (up), 1 = toward MAX_POS (down)
  assign req_up  = up & ~down;
  assign req_dn  = down & ~up;
  assign has_req = req_up | req_dn;
  assign req_dir = req_dn;

  always_comb begin
    state_n = state;
    dir_n   = dir;
    timer_n = timer;
    pos_n   = pos;
    moved_n = 1'b0;
    do_step = 1'b0;
    if (recenter) begin
      state_n = IDLE;
      pos_n   = RESET_P;
      moved_n = (pos != RESET_P);
    end else if (!enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (has_req) begin
            do_step = 1'b1;
            dir_n   = req_dir;
            timer_n = DELAY_T;
            state_n = HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!has_req) begin
            state_n = IDLE;
          end else if (req_dir != dir) begin
            do_step = 1'b1;
            dir_n   = req_dir;
            timer_n = DELAY_T;
            state_n = HOLD;
          end else if (timer == '0) begin
            do_step = 1'b1;
            timer_n = RATE_T;
            state_n = REPEAT;
          end else begin
            timer_n = timer - 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
      // A step that would leave the playfield is dropped; the timer still advances
      if (do_step) begin
        if (!req_dir && pos != '0) begin
          pos_n   = pos - 1'b1;
          moved_n = 1'b1;
        end else if (req_dir && pos != MAX_P) begin
          pos_n   = pos + 1'b1;
          moved_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dir   <= 1'b0;
      timer <= '0;
      pos   <= RESET_P;
      moved <= 1'b0;
    end else begin
      state <= state_n;
      dir   <= dir_n;
      timer <= timer_n;
      pos   <= pos_n;
      moved <= moved_n;
    end
  end

  assign at_top    = (pos == '0);
  assign at_bottom = (pos == MAX_P);

endmodule

// File: doc/paddle_controller.md
Name: paddle_controller

Overview:
- Consumes the debounced up/down button levels from the button debouncers and produces the paddle's vertical position for the Pong game logic and the renderer.
- A press moves the paddle one step immediately.
- Holding the button auto-repeats, first after a long initial delay and then at a faster repeat rate.
- Position is clamped to the playfield, and a synchronous recenter input restores the start position.

Parameters:
- POS_WIDTH, 5, width of the position output.
- MAX_POS, 27, largest legal position (paddle top row); legal range is 0..MAX_POS. Must satisfy MAX_POS < 2**POS_WIDTH.
- RESET_POS, 14, position after reset or recenter. Must satisfy RESET_POS <= MAX_POS.
- DELAY_CYCLES, 2500000, cycles from the first move to the first auto-repeat move. Must be >= 2.
- RATE_CYCLES, 500000, cycles between subsequent auto-repeat moves. Must be >= 2.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- up  input  1  debounced level, synchronous to clock; 1 = move toward 0.
- down  input  1  debounced level, synchronous to clock; 1 = move toward MAX_POS.
- enable  input  1  1 = paddle may move; 0 = frozen (game paused or serving).
- recenter  input  1  synchronous one-cycle request to load RESET_POS.
- pos  output  POS_WIDTH  current paddle position, registered.
- moved  output  1  one-cycle pulse, high in the first cycle pos shows a new value.
- at_top  output  1  combinational from the register: pos == 0.
- at_bottom  output  1  combinational from the register: pos == MAX_POS.

Behaviour:
- Reset (asynchronous):
  - pos = RESET_POS, moved = 0, state = IDLE, dir = up, timer = 0.
  - at_top and at_bottom reflect RESET_POS.
- Effective request:
  - req_up = up & ~down, req_dn = down & ~up.
  - Both buttons or neither = no request.
- A "step" is pos-1 for up or pos+1 for down.
  - A step is suppressed when it would leave 0..MAX_POS: pos is held and moved stays 0.
  - The state machine and timer proceed exactly as if the step had occurred.
  - pos never wraps.
- State machine (states IDLE, HOLD, REPEAT), evaluated per edge in this priority order:
  1. recenter = 1: pos <= RESET_POS, state <= IDLE, moved <= (RESET_POS != pos). Overrides everything below.
  2. enable = 0: state <= IDLE, pos held, moved <= 0.
  3. IDLE with a request: step, dir <= request, timer <= DELAY_CYCLES-1, state <= HOLD.
  4. HOLD or REPEAT with no request: state <= IDLE, no step.
  5. HOLD or REPEAT with a request opposite to dir: treat as a new press; step in the new direction, dir updated, timer <= DELAY_CYCLES-1, state <= HOLD.
  6. HOLD with the same request:
     - timer == 0: step, timer <= RATE_CYCLES-1, state <= REPEAT.
     - otherwise: timer <= timer-1.
  7. REPEAT with the same request:
     - timer == 0: step, timer <= RATE_CYCLES-1.
     - otherwise: timer <= timer-1.
- Latency and moved timing:
  - A request first sampled at edge k updates pos at edge k, so it is visible in the following cycle.
  - moved is registered alongside pos and is high for exactly that one cycle.
- Repeat timing:
  - First repeat step occurs DELAY_CYCLES edges after the initial step.
  - Later repeat steps occur every RATE_CYCLES edges.
- Timer width: $clog2(max(DELAY_CYCLES, RATE_CYCLES)).
- Arithmetic: unsigned, POS_WIDTH bits; clamp checks are done before the add or subtract.
- Reset asserted mid-hold: immediate return to the reset values; no step on the first edge after reset deasserts unless a request is present (that edge is an IDLE press).

Test Plan:
Bench overrides DELAY_CYCLES=8, RATE_CYCLES=4; other parameters at defaults.
1. Reset, then up=1 held for edges 0..19, then released -> pos 13 after edge 0, 12 after edge 8, 11 after edge 12, 10 after edge 16; exactly 4 moved pulses; state IDLE after release.
2. Single tap: down=1 for one edge from pos 14 -> pos 15, moved high for one cycle, no further steps over the next 20 cycles.
3. Hold down from 14 for 100 edges -> pos reaches 27 and stays; at_bottom=1; no moved pulse once clamped; pos never exceeds 27 and never wraps to 0.
4. Both up and down high from IDLE for 10 edges -> pos unchanged, moved=0. Then a switch mid-hold: up held 5 edges, then down on edge 5 -> pos 13 after edge 0, 14 after edge 5, next repeat step at edge 13.
5. Hold up with enable dropped at edge 6 for 4 edges, then restored while up still held -> no steps while disabled; a fresh immediate step at edge 10; the delay timer restarts from that step.
6. recenter pulse while at pos 3 and up held -> pos 14 the next cycle, moved=1, state IDLE. An asynchronous reset asserted mid-REPEAT forces pos=14 without waiting for a clock edge.
